// File: rtl/vga_text_scan_ctrl_if.sv
// Datapath bus between the scan controller and the colour/lookup datapath.
// The controller issues pixel/character addresses and takes back the colour.
interface vga_text_scan_ctrl_if;
   logic [6:0]  pa;  // scanline_in_char*8 + pixel_in_char
   logic [10:0] ca;  // char_row*80 + char_col
   logic [7:0]  p;   // colour returned by the datapath

   modport master (output pa, output ca, input p);
   modport slave  (input pa, input ca, output p);
endinterface

// File: rtl/vga_text_scan_ctrl.sv
// Scan sequencer for the 80x25 text-mode colour datapath. Divides sys_clk down
// to pixel ticks, runs the h/v raster counters, issues pixel and character
// addresses, and delays sync/blank so they line up with the returned colour.
module vga_text_scan_ctrl #(
   parameter int unsigned CLK_DIV  = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 350,
   parameter int unsigned V_FP     = 37,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 60,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned PIPE_LAT = 1
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic                        en,
   vga_text_scan_ctrl_if.master        dp,
   output logic [7:0]                  vga_p,
   output logic                        vga_hs,
   output logic                        vga_vs,
   output logic                        vga_de,
   output logic                        pix_tick,
   output logic                        frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [9:0]  HLast    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  HActive  = 10'(H_ACTIVE);
   localparam logic [9:0]  HsStart  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HsEnd    = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [8:0]  VLast    = 9'(V_TOTAL - 1);
   localparam logic [8:0]  VActive  = 9'(V_ACTIVE);
   localparam logic [8:0]  VsStart  = 9'(V_ACTIVE + V_FP);
   localparam logic [8:0]  VsEnd    = 9'(V_ACTIVE + V_FP + V_SYNC);
   // Glyphs are 8x14, text rows are 80 characters wide.
   localparam logic [3:0]  LicLast  = 4'd13;
   localparam logic [10:0] Cols     = 11'd80;

   logic [DivW-1:0]     divcnt_q, divcnt_d;
   logic [9:0]          hcnt_q, hcnt_d;
   logic [8:0]          vcnt_q, vcnt_d;
   logic [3:0]          lic_q, lic_d;
   logic [4:0]          char_row_q, char_row_d;
   logic [10:0]         row_base_q, row_base_d;
   logic [6:0]          pa_q, pa_d;
   logic [10:0]         ca_q, ca_d;
   logic [7:0]          vga_p_q, vga_p_d;
   logic                vga_hs_q, vga_hs_d;
   logic                vga_vs_q, vga_vs_d;
   logic                vga_de_q, vga_de_d;
   logic                pix_tick_q, pix_tick_d;
   logic                frame_start_q, frame_start_d;
   logic [PIPE_LAT-1:0] dl_hs_q, dl_hs_d;
   logic [PIPE_LAT-1:0] dl_vs_q, dl_vs_d;
   logic [PIPE_LAT-1:0] dl_de_q, dl_de_d;

   logic div_last;
   logic hs_raw, vs_raw, de_raw;

   // Raw sync/blank decoded from the current raster position.
   always_comb begin
      hs_raw = (hcnt_q >= HsStart) && (hcnt_q < HsEnd);
      vs_raw = (vcnt_q >= VsStart) && (vcnt_q < VsEnd);
      de_raw = (hcnt_q < HActive) && (vcnt_q < VActive);
   end

   // Next-state: divider, raster/character counters, addresses, delay line, outputs.
   always_comb begin
      divcnt_d      = divcnt_q;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      lic_d         = lic_q;
      char_row_d    = char_row_q;
      row_base_d    = row_base_q;
      pa_d          = pa_q;
      ca_d          = ca_q;
      vga_p_d       = vga_p_q;
      vga_hs_d      = vga_hs_q;
      vga_vs_d      = vga_vs_q;
      vga_de_d      = vga_de_q;
      dl_hs_d       = dl_hs_q;
      dl_vs_d       = dl_vs_q;
      dl_de_d       = dl_de_q;

      div_last      = (divcnt_q == DivLast);
      divcnt_d      = div_last ? '0 : divcnt_q + DivW'(1);
      // pix_tick is high during the cycle whose closing edge advances the raster.
      pix_tick_d    = div_last;
      frame_start_d = div_last && (hcnt_q == '0) && (vcnt_q == '0);

      if (pix_tick_q) begin
         if (hcnt_q == HLast) begin
            hcnt_d = '0;
            if (vcnt_q == VLast) begin
               vcnt_d     = '0;
               lic_d      = '0;
               char_row_d = '0;
               row_base_d = '0;
            end else begin
               vcnt_d = vcnt_q + 9'd1;
               if (vcnt_q < VActive) begin
                  if (lic_q == LicLast) begin
                     lic_d      = '0;
                     char_row_d = char_row_q + 5'd1;
                     row_base_d = row_base_q + Cols;
                  end else begin
                     lic_d = lic_q + 4'd1;
                  end
               end
            end
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end

         // Addresses track the position the raster is about to enter.
         if ((hcnt_d < HActive) && (vcnt_d < VActive)) begin
            ca_d = row_base_d + {4'b0000, hcnt_d[9:3]};
            pa_d = {lic_d, hcnt_d[2:0]};
         end else begin
            ca_d = '0;
            pa_d = '0;
         end

         dl_hs_d[0] = hs_raw;
         dl_vs_d[0] = vs_raw;
         dl_de_d[0] = de_raw;
         for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            dl_hs_d[i] = dl_hs_q[i-1];
            dl_vs_d[i] = dl_vs_q[i-1];
            dl_de_d[i] = dl_de_q[i-1];
         end

         // Output register is the final alignment stage; p belongs to the same pixel.
         vga_hs_d = dl_hs_q[PIPE_LAT-1] ? HS_POL : ~HS_POL;
         vga_vs_d = dl_vs_q[PIPE_LAT-1] ? VS_POL : ~VS_POL;
         vga_de_d = dl_de_q[PIPE_LAT-1];
         vga_p_d  = dl_de_q[PIPE_LAT-1] ? dp.p : 8'h00;
      end

      // Disable blanks immediately and parks everything at the frame origin.
      if (!en) begin
         divcnt_d      = '0;
         hcnt_d        = '0;
         vcnt_d        = '0;
         lic_d         = '0;
         char_row_d    = '0;
         row_base_d    = '0;
         pa_d          = '0;
         ca_d          = '0;
         vga_p_d       = '0;
         vga_hs_d      = ~HS_POL;
         vga_vs_d      = ~VS_POL;
         vga_de_d      = 1'b0;
         pix_tick_d    = 1'b0;
         frame_start_d = 1'b0;
         dl_hs_d       = '0;
         dl_vs_d       = '0;
         dl_de_d       = '0;
      end
   end

   // State register with asynchronous reset to the blanked frame origin.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         divcnt_q      <= '0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         lic_q         <= '0;
         char_row_q    <= '0;
         row_base_q    <= '0;
         pa_q          <= '0;
         ca_q          <= '0;
         vga_p_q       <= '0;
         vga_hs_q      <= ~HS_POL;
         vga_vs_q      <= ~VS_POL;
         vga_de_q      <= 1'b0;
         pix_tick_q    <= 1'b0;
         frame_start_q <= 1'b0;
         dl_hs_q       <= '0;
         dl_vs_q       <= '0;
         dl_de_q       <= '0;
      end else begin
         divcnt_q      <= divcnt_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         lic_q         <= lic_d;
         char_row_q    <= char_row_d;
         row_base_q    <= row_base_d;
         pa_q          <= pa_d;
         ca_q          <= ca_d;
         vga_p_q       <= vga_p_d;
         vga_hs_q      <= vga_hs_d;
         vga_vs_q      <= vga_vs_d;
         vga_de_q      <= vga_de_d;
         pix_tick_q    <= pix_tick_d;
         frame_start_q <= frame_start_d;
         dl_hs_q       <= dl_hs_d;
         dl_vs_q       <= dl_vs_d;
         dl_de_q       <= dl_de_d;
      end
   end

   assign dp.pa       = pa_q;
   assign dp.ca       = ca_q;
   assign vga_p       = vga_p_q;
   assign vga_hs      = vga_hs_q;
   assign vga_vs      = vga_vs_q;
   assign vga_de      = vga_de_q;
   assign pix_tick    = pix_tick_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_text_scan_ctrl.sv
// Bench for vga_text_scan_ctrl on a shrunken raster (48x38 ticks, 32x30 active)
// so a whole frame fits in a short run; divider and polarities stay at defaults.
module tb_vga_text_scan_ctrl;

   localparam int CDiv = 4;
   localparam int HT   = 48;   // 32 + 4 + 8 + 4
   localparam int VT   = 38;   // 30 + 3 + 2 + 3
   localparam int FT   = HT * VT;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       en;
   logic [7:0] vga_p;
   logic       vga_hs, vga_vs, vga_de, pix_tick, frame_start;

   vga_text_scan_ctrl_if dp ();

   vga_text_scan_ctrl #(
      .CLK_DIV  (CDiv),
      .H_ACTIVE (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_ACTIVE (30), .V_FP (3), .V_SYNC (2), .V_BP (3)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .en          (en),
      .dp          (dp),
      .vga_p       (vga_p),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_de      (vga_de),
      .pix_tick    (pix_tick),
      .frame_start (frame_start)
   );

   always #5 sys_clk = ~sys_clk;

   // Datapath stand-in: colour = low 7 bits of ca, one tick of read latency.
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) dp.p <= 8'h00;
      else if (pix_tick) dp.p <= {1'b0, dp.ca[6:0]};
   end

   int n_vec = 0;
   int n_bad = 0;

   // Directed address vectors: {hcnt, vcnt, ca, pa}.
   int tab [9][4] = '{'{0, 0, 0, 0},     '{17, 0, 2, 1},     '{7, 13, 0, 111},
                      '{9, 14, 81, 1},   '{17, 29, 162, 9},  '{31, 29, 163, 15},
                      '{32, 29, 0, 0},   '{5, 30, 0, 0},     '{31, 27, 83, 111}};

   int bad_trk, bad_p, hs_hi, de_hi, vs_lo, fs_cnt, fs_at_ft;
   int hs_rise, hs_fall, vs_fall, de_rise;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
   endtask

   task automatic next_tick();
      int n;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!pix_tick && n < 3 * CDiv);
      if (!pix_tick) begin
         check("tick_timeout", 32'd0, 32'd1);
         finish_run();
         $fatal(1, "no pixel tick within bound");
      end
   endtask

   // Called right after a negedge on which reset was released or en raised.
   task automatic first_tick(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!pix_tick && n < 3 * CDiv);
      check({tag, "_tick_lat"}, n, CDiv);
      check({tag, "_frame_start"}, frame_start, 1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_hs"}, vga_hs, 0);
      check({tag, "_vs"}, vga_vs, 1);
      check({tag, "_de"}, vga_de, 0);
      check({tag, "_vga_p"}, vga_p, 0);
      check({tag, "_pa"}, dp.pa, 0);
      check({tag, "_ca"}, dp.ca, 0);
   endtask

   // Walk ticks 0..last of a frame starting at the current tick cycle.
   task automatic scan(input int last);
      int  hc, vc, ph, pv, exp_p;
      bit  exp_de, exp_hs, exp_vsa;
      logic prev_hs, prev_vs, prev_de;
      bad_trk = 0; bad_p = 0; hs_hi = 0; de_hi = 0; vs_lo = 0; fs_cnt = 0; fs_at_ft = 0;
      hs_rise = -1; hs_fall = -1; vs_fall = -1; de_rise = -1;
      prev_hs = 1'b0; prev_vs = 1'b1; prev_de = 1'b0;
      for (int j = 0; j <= last; j++) begin
         if (j > 0) next_tick();
         hc = j % HT;
         vc = (j / HT) % VT;
         if (j > 0 && frame_start) fs_cnt++;
         if (j == FT) fs_at_ft = int'(frame_start);
         for (int k = 0; k < 9; k++) begin
            if (j < FT && hc == tab[k][0] && vc == tab[k][1]) begin
               check($sformatf("ca@%0d,%0d", hc, vc), dp.ca, tab[k][2]);
               check($sformatf("pa@%0d,%0d", hc, vc), dp.pa, tab[k][3]);
            end
         end
         if (j >= 2) begin
            ph      = (j - 2) % HT;
            pv      = ((j - 2) / HT) % VT;
            exp_de  = (ph < 32) && (pv < 30);
            exp_hs  = (ph >= 36) && (ph <= 43);
            exp_vsa = (pv >= 33) && (pv <= 34);
            exp_p   = exp_de ? (((pv / 14) * 80 + ph / 8) & 127) : 0;
            if (vga_de !== exp_de || vga_hs !== exp_hs || vga_vs !== !exp_vsa) bad_trk++;
            if (vga_p !== 8'(exp_p)) bad_p++;
            hs_hi += int'(vga_hs);
            de_hi += int'(vga_de);
            vs_lo += int'(!vga_vs);
            if (vga_hs && !prev_hs && hs_rise < 0) hs_rise = j;
            if (!vga_hs && prev_hs && hs_fall < 0) hs_fall = j;
            if (!vga_vs && prev_vs && vs_fall < 0) vs_fall = j;
            if (vga_de && !prev_de && de_rise < 0) de_rise = j;
            prev_hs = vga_hs;
            prev_vs = vga_vs;
            prev_de = vga_de;
         end
      end
      check("sync_de_track", bad_trk, 0);
      check("vga_p_track", bad_p, 0);
   endtask

   initial begin
      sys_rst = 1'b1;
      en      = 1'b1;
      repeat (3) @(negedge sys_clk);
      check_idle("rst");
      check("rst_pix_tick", pix_tick, 0);
      check("rst_frame_start", frame_start, 0);
      sys_rst = 1'b0;
      first_tick("rst_rel");

      // One full frame of outputs (positions 0..FT-1 land on ticks 2..FT+1).
      scan(FT + 1);
      check("de_rise", de_rise, 2);
      check("de_fall_free_hs_rise", hs_rise, 38);
      check("hs_fall", hs_fall, 46);
      check("vs_fall", vs_fall, 33 * HT + 2);
      check("hs_ticks", hs_hi, 8 * VT);
      check("de_ticks", de_hi, 32 * 30);
      check("vs_low_ticks", vs_lo, 2 * HT);
      check("frame_start_count", fs_cnt, 1);
      check("frame_start_period", fs_at_ft, 1);

      // Now at frame position 1; advance to (5,10) and drop en mid-frame.
      repeat (10 * HT + 4) next_tick();
      check("pre_drop_de", vga_de, 1);
      check("pre_drop_ca", dp.ca, 0);
      en = 1'b0;
      @(negedge sys_clk);
      check_idle("en_low");
      check("en_low_pix_tick", pix_tick, 0);
      repeat (5) @(negedge sys_clk);
      check("en_low_hold_pa", dp.pa, 0);
      en = 1'b1;
      first_tick("en_rise");
      scan(60);

      // At position (12,1): drop reset between edges, outputs must clear at once.
      check("pre_rst_de", vga_de, 1);
      check("pre_rst_pa", dp.pa, 12);
      #2 sys_rst = 1'b1;
      #1 check_idle("rst_async");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      first_tick("rst2_rel");
      scan(20);

      finish_run();
      $finish;
   end

endmodule
